gbuf_acc_drain: RTL and testbench

- Reader/initiator for the accumulating global buffer BRAM (DATA_BITS=128, four int32 lanes).
- After a conv/FC pass finishes accumulating partial sums, this block reads a contiguous range of entries and streams them out on a valid/ready port.
- Optionally writes each entry back to zero after reading, so the next accumulation pass starts clean.
- Sits between the accumulator buffer and the post-processing (requant/activation) stage.

---
 rtl/gbuf_acc_drain.sv | 161 ++++++++++++++++
 tb/tb_gbuf_acc_drain.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbuf_acc_drain.sv
// Drains a contiguous range of the accumulating global buffer onto a valid/ready stream,
// optionally zeroing each entry after it is read.
module gbuf_acc_drain #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   count,
  input  logic                 clear_en,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_en,
  output logic                 wr_en,
  output logic                 acc_mode,
  output logic [ADDR_BITS-1:0] index,
  output logic [DATA_BITS-1:0] ram_wdata,
  input  logic [DATA_BITS-1:0] ram_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_BITS-1:0] out_data
);

  typedef enum logic [1:0] {StIdle, StRd, StCap, StFlush} state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic [ADDR_BITS:0]   rem_q, rem_d;
  logic                 clr_q, clr_d;
  logic                 zero_done_q, zero_done_d;
  logic                 rd_pend_q;

  logic [DATA_BITS-1:0] fifo_q [2];
  logic                 wptr_q, rptr_q;
  logic [1:0]           cnt_q;

  logic       push, pop, credit, issue_rd, flush_ok;
  logic [1:0] occ_next;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_q[rptr_q] : '0;
  assign push      = rd_pend_q;
  assign pop       = out_valid && out_ready;

  // A same-cycle pop frees its slot, which keeps back-to-back reads at one per cycle.
  assign occ_next = cnt_q - {1'b0, pop};
  assign credit   = (occ_next + {1'b0, rd_pend_q}) < 2'd2;
  assign issue_rd = (state_q == StRd) && credit;
  assign flush_ok = (state_q == StFlush) && !rd_pend_q && (cnt_q == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    clr_d       = clr_q;
    zero_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (count != '0) begin
            state_d = StRd;
            ptr_d   = base_addr;
            rem_d   = count;
            clr_d   = clear_en;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      StRd: begin
        if (credit) begin
          ptr_d = ptr_q + ADDR_BITS'(1);
          rem_d = rem_q - (ADDR_BITS+1)'(1);
          if (clr_q) begin
            state_d = StCap;
          end else if (rem_q == (ADDR_BITS+1)'(1)) begin
            state_d = StFlush;
          end
        end
      end
      StCap: begin
        state_d = (rem_q != '0) ? StRd : StFlush;
      end
      StFlush: begin
        if (flush_ok) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = flush_ok || zero_done_q;
    ram_en    = 1'b0;
    wr_en     = 1'b0;
    acc_mode  = 1'b0;
    index     = '0;
    ram_wdata = '0;
    unique case (state_q)
      StRd: begin
        ram_en = credit;
        index  = credit ? ptr_q : '0;
      end
      StCap: begin
        // ptr has already advanced past the entry just read.
        ram_en = 1'b1;
        wr_en  = 1'b1;
        index  = ptr_q - ADDR_BITS'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rem_q       <= '0;
      clr_q       <= 1'b0;
      zero_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      clr_q       <= clr_d;
      zero_done_q <= zero_done_d;
      rd_pend_q   <= issue_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= ram_rdata;
        wptr_q         <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_gbuf_acc_drain.sv
// Directed bench for gbuf_acc_drain: BRAM model, expected-beat scoreboard and per-cycle monitor.
module tb_gbuf_acc_drain;
  localparam int AB    = 8;
  localparam int DB    = 128;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AB-1:0] base_addr = '0;
  logic [AB:0]   count = '0;
  logic          clear_en = 1'b0;
  logic          busy, done, ram_en, wr_en, acc_mode, out_valid;
  logic          out_ready = 1'b1;
  logic [AB-1:0] index;
  logic [DB-1:0] ram_wdata, out_data;
  logic [DB-1:0] ram_rdata = '0;

  always #5 clk = ~clk;

  gbuf_acc_drain #(.ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .clear_en(clear_en), .busy(busy), .done(done), .ram_en(ram_en), .wr_en(wr_en),
    .acc_mode(acc_mode), .index(index), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // BRAM model with a bench-only preload port
  logic [DB-1:0] mem [DEPTH];
  logic          pre_we = 1'b0;
  logic [AB-1:0] pre_addr = '0;
  logic [DB-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (ram_en) begin
      if (wr_en) mem[index] <= acc_mode ? mem[index] + ram_wdata : ram_wdata;
      else ram_rdata <= mem[index];
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic logic [DB-1:0] pat(input int k);
    return {32'(k), 32'(-k), 32'(k + 100), 32'hFFFF_FFFF};
  endfunction

  // Scoreboard: expected beats, expected read indices, expected done cycle
  logic [DB-1:0] exp_q[$];
  logic [AB-1:0] exp_idx[$];
  int            exp_done_at = -1;
  int            start_cyc = 0;
  int            rd_seen = 0, beats = 0;
  int            drain_beats = 0, first_cyc = 0, last_cyc = 0, wr_cnt = 0;
  logic [DB-1:0] first_data = '0;
  logic [AB-1:0] last_rd = '0;
  logic          prev_stall = 1'b0;
  logic [DB-1:0] prev_data = '0;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (busy) check_int("buffered_le2", int'((rd_seen - beats) <= 2), 1);
      if (prev_stall) begin
        check_int("hold_valid", int'(out_valid), 1);
        check("hold_data", out_data, prev_data);
      end
      if (ram_en && !wr_en) begin
        if (exp_idx.size() == 0) fail_now("extra_read", $sformatf("index %0d", index));
        else begin
          check_int("rd_index", int'(index), int'(exp_idx[0]));
          void'(exp_idx.pop_front());
        end
        last_rd = index;
        rd_seen++;
      end
      if (ram_en && wr_en) begin
        check_int("wr_index", int'(index), int'(last_rd));
        check_int("wr_acc_mode", int'(acc_mode), 0);
        check("wr_data", ram_wdata, '0);
        wr_cnt++;
      end
      if (done) begin
        check_int("done_cycle", cyc, exp_done_at);
        exp_done_at = -1;
      end else if (cyc == exp_done_at) begin
        fail_now("done_missing", $sformatf("no done at cycle %0d", cyc));
        exp_done_at = -1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("extra_beat", $sformatf("data %h", out_data));
        else begin
          check("beat_data", out_data, exp_q[0]);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) exp_done_at = cyc + 1;
        end
        if (drain_beats == 0) begin
          first_cyc  = cyc;
          first_data = out_data;
        end
        last_cyc = cyc;
        drain_beats++;
        beats++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_start(input logic [AB-1:0] b, input logic [AB:0] n, input logic c,
                          input logic accept);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; count = n; clear_en = c;
    if (accept) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_idx.push_back(AB'(int'(b) + i));
        exp_q.push_back(mem[AB'(int'(b) + i)]);
      end
      if (n == '0) exp_done_at = cyc + 1;
      drain_beats = 0;
      wr_cnt      = 0;
      start_cyc   = cyc;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (accept) check_int("busy_after_start", int'(busy), int'(n != '0));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && exp_idx.size() == 0 && exp_done_at == -1 && !busy) return;
    end
    fail_now(name, $sformatf("drain timeout, %0d beats left", exp_q.size()));
  endtask

  task automatic wait_beats(input int k);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (drain_beats >= k) return;
    end
    fail_now("wait_beats", $sformatf("only %0d of %0d beats", drain_beats, k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_ram_en", int'(ram_en), 0);
    check_int("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", out_data, '0);

    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk); #1;
      pre_we = 1'b1; pre_addr = AB'(k); pre_data = pat(k);
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
    rst_n  = 1'b1;

    // Plain drain 0..3
    do_start(8'd0, 9'd4, 1'b0, 1'b1);
    wait_drain("t1");
    check_int("t1_latency", first_cyc - start_cyc, 3);
    check_int("t1_span", last_cyc - first_cyc, 3);
    check_int("t1_beats", drain_beats, 4);
    check("t1_first", first_data, 128'h00000000_00000000_00000064_FFFFFFFF);
    check_int("t1_writes", wr_cnt, 0);
    for (int k = 0; k < 4; k++) check("t1_mem_kept", mem[k], pat(k));

    // Address wrap 254,255,0,1
    do_start(8'd254, 9'd4, 1'b0, 1'b1);
    wait_drain("wrap");
    check("wrap_first", first_data, 128'h000000FE_FFFFFF02_00000162_FFFFFFFF);
    check_int("wrap_beats", drain_beats, 4);

    // Backpressure with an ignored start while busy
    do_start(8'd16, 9'd8, 1'b0, 1'b1);
    wait_beats(2);
    out_ready = 1'b0;
    do_start(8'd100, 9'd1, 1'b1, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("bp");
    check_int("bp_beats", drain_beats, 8);
    check_int("bp_writes", wr_cnt, 0);
    check("bp_ignored_mem", mem[100], pat(100));

    // Zero-length drain
    do_start(8'd5, 9'd0, 1'b0, 1'b1);
    wait_drain("zero");
    check_int("zero_beats", drain_beats, 0);

    // Full-depth drain
    do_start(8'd7, 9'd256, 1'b0, 1'b1);
    wait_drain("full");
    check_int("full_beats", drain_beats, 256);
    check_int("full_span", last_cyc - first_cyc, 255);

    // Drain with clear
    do_start(8'd0, 9'd4, 1'b1, 1'b1);
    wait_drain("clr");
    check_int("clr_latency", first_cyc - start_cyc, 3);
    check_int("clr_span", last_cyc - first_cyc, 6);
    check_int("clr_writes", wr_cnt, 4);
    for (int k = 0; k < 4; k++) check("clr_mem_zero", mem[k], '0);

    // Reset mid-drain
    do_start(8'd32, 9'd8, 1'b1, 1'b1);
    wait_beats(3);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_int("mid_rst_busy", int'(busy), 0);
    check_int("mid_rst_done", int'(done), 0);
    check_int("mid_rst_ram_en", int'(ram_en), 0);
    check_int("mid_rst_wr_en", int'(wr_en), 0);
    check_int("mid_rst_acc_mode", int'(acc_mode), 0);
    check_int("mid_rst_index", int'(index), 0);
    check("mid_rst_wdata", ram_wdata, '0);
    check_int("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", out_data, '0);
    exp_q.delete();
    exp_idx.delete();
    exp_done_at = -1;
    rd_seen = 0;
    beats = 0;
    repeat (3) @(posedge clk);
    #1;
    check_int("in_rst_done", int'(done), 0);
    rst_n = 1'b1;
    for (int k = 36; k < 40; k++) check("rst_untouched", mem[k], pat(k));

    do_start(8'd10, 9'd3, 1'b0, 1'b1);
    wait_drain("post_rst");
    check_int("post_rst_beats", drain_beats, 3);
    check_int("post_rst_latency", first_cyc - start_cyc, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
